// File: rtl/rr_channel_mux.sv
// N-channel to one mux with fixed or round-robin grant and a one-entry output register.
// Optional: define RR_CHANNEL_MUX_XFER_CNT_EN to add the saturating xfer_cnt output.
module rr_channel_mux #(
  parameter int WIDTH = 4,
  parameter int N     = 4,
  localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_sel
`ifdef RR_CHANNEL_MUX_XFER_CNT_EN
  ,
  output logic [15:0]          xfer_cnt
`endif
);

  localparam logic EMPTY = 1'b0;
  localparam logic FULL  = 1'b1;

  logic            state;
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] gnt;
  logic            gnt_vld;
  logic            can_load;
  logic            xfer;
  logic            pop;
  int              idx;

  assign can_load  = (state == EMPTY) || out_ready;
  assign out_valid = (state == FULL);
  assign pop       = out_valid && out_ready;
  assign xfer      = rst_n && gnt_vld && can_load;

  // Descending scan so the channel closest to ptr wins.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    if (mode) begin
      for (int k = N - 1; k >= 0; k--) begin
        idx = (int'(ptr) + k) % N;
        if (in_valid[idx]) begin
          gnt_vld = 1'b1;
          gnt     = SELW'(idx);
        end
      end
    end else if (int'(sel) < N) begin
      gnt     = sel;
      gnt_vld = in_valid[sel];
    end
  end

  always_comb begin
    in_ready = '0;
    if (xfer)
      in_ready[gnt] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      out_data <= '0;
      out_sel  <= '0;
      ptr      <= '0;
    end else begin
      if (xfer) begin
        state    <= FULL;
        out_data <= in_data[gnt*WIDTH +: WIDTH];
        out_sel  <= gnt;
        if (mode)
          ptr <= (int'(gnt) == N - 1) ? '0 : gnt + 1'b1;
      end else if (pop) begin
        state <= EMPTY;
      end
    end
  end

`ifdef RR_CHANNEL_MUX_XFER_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      xfer_cnt <= '0;
    else if (pop && xfer_cnt != 16'hFFFF)
      xfer_cnt <= xfer_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_rr_channel_mux.sv
// Directed self-checking bench for rr_channel_mux (WIDTH=4, N=4).
// Counter checks run only when RR_CHANNEL_MUX_XFER_CNT_EN is defined.
module tb_rr_channel_mux;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_sel;
`ifdef RR_CHANNEL_MUX_XFER_CNT_EN
  logic [15:0] xfer_cnt;
`endif

  int n_chk;
  int n_err;

  rr_channel_mux #(.WIDTH(4), .N(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel)
`ifdef RR_CHANNEL_MUX_XFER_CNT_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_data   = 16'hDCBA;
    in_valid  = 4'hF;
    mode      = 1'b1;
    sel       = 2'd0;
    out_ready = 1'b1;
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_sel", 32'(out_sel), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rr_rdy0", 32'(in_ready), 32'h1);

    // Round-robin streaming: A,B,C,D,A with no bubbles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_valid", 32'(out_valid), 32'd1);
      chk("rr_sel", 32'(out_sel), 32'(i % 4));
      chk("rr_data", 32'(out_data), 32'(4'hA + i % 4));
    end

    // Fixed select channel 2 (ptr now 1)
    mode     = 1'b0;
    sel      = 2'd2;
    in_valid = 4'b0100;
    in_data  = 16'h0900;
    #1;
    chk("fix_rdy", 32'(in_ready), 32'h4);
    tick();
    chk("fix_valid", 32'(out_valid), 32'd1);
    chk("fix_data", 32'(out_data), 32'h9);
    chk("fix_sel", 32'(out_sel), 32'd2);

    // Load 5 from channel 1, then stall
    sel      = 2'd1;
    in_valid = 4'b0010;
    in_data  = 16'h0050;
    tick();
    chk("ld5_data", 32'(out_data), 32'h5);
    chk("ld5_sel", 32'(out_sel), 32'd1);
    out_ready = 1'b0;
    in_valid  = 4'hF;
    for (int i = 0; i < 3; i++) begin
      mode = i[0];
      sel  = 2'(i);
      #1;
      chk("stall_rdy", 32'(in_ready), 32'd0);
      tick();
      chk("stall_data", 32'(out_data), 32'h5);
      chk("stall_sel", 32'(out_sel), 32'd1);
      chk("stall_valid", 32'(out_valid), 32'd1);
    end
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("empty_keep", 32'(out_data), 32'h5);

    // ptr still 1: grant 2 moves ptr to 3
    mode     = 1'b1;
    in_valid = 4'b0100;
    in_data  = 16'h4321;
    tick();
    chk("p3_sel", 32'(out_sel), 32'd2);
    in_valid = 4'b0011;
    #1;
    chk("wrap_rdy", 32'(in_ready), 32'h1);
    tick();
    chk("wrap_sel", 32'(out_sel), 32'd0);
    chk("wrap_data", 32'(out_data), 32'h1);
    chk("next_rdy", 32'(in_ready), 32'h2);
    tick();
    chk("next_sel", 32'(out_sel), 32'd1);
    chk("next_data", 32'(out_data), 32'h2);

    // Fixed select of an idle channel: no grant
    mode     = 1'b0;
    sel      = 2'd3;
    in_valid = 4'b0111;
    #1;
    chk("nogrant", 32'(in_ready), 32'd0);

    // Reset while FULL and stalled
    out_ready = 1'b0;
    tick();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data", 32'(out_data), 32'd0);
    chk("arst_rdy", 32'(in_ready), 32'd0);
    #1;
    rst_n     = 1'b1;
    mode      = 1'b1;
    in_valid  = 4'b1100;
    in_data   = 16'h8700;
    #1;
    chk("post_rdy", 32'(in_ready), 32'h4);
    tick();
    chk("post_sel", 32'(out_sel), 32'd2);
    chk("post_data", 32'(out_data), 32'h7);

`ifdef RR_CHANNEL_MUX_XFER_CNT_EN
    rst_n = 1'b0;
    #1;
    chk("cnt_rst0", 32'(xfer_cnt), 32'd0);
    rst_n     = 1'b1;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < 70000; i++)
      tick();
    chk("cnt_sat", 32'(xfer_cnt), 32'hFFFF);
    rst_n = 1'b0;
    #1;
    chk("cnt_rst", 32'(xfer_cnt), 32'd0);
    rst_n = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
